accumulation_drain: RTL and testbench



---
 rtl/accumulation_drain_pkg.sv | 19 +
 rtl/accumulation_drain_prefetch_fifo.sv | 60 ++++++
 rtl/accumulation_drain.sv | 142 ++++++++++++++
 tb/tb_accumulation_drain.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulation_drain_pkg.sv
// Shared definitions for the accumulation-buffer write-back drain engine.
package accumulation_drain_pkg;

    localparam int DEF_DATA_WIDTH      = 64;
    localparam int DEF_OUT_WIDTH       = 16;
    localparam int DEF_BANK_ADDR_WIDTH = 7;
    localparam int DEF_BANK_DEPTH      = 128;

    // FSM encoding (plain constants so older tools and waveform scripts can match them)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    // Number of output beats that one buffer word is split into
    function automatic int beats_of(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

endpackage

// File: rtl/accumulation_drain_prefetch_fifo.sv
// Two-entry synchronous FIFO used to hold prefetched buffer words ahead of
// a stream serializer. Push while full and pop while empty are ignored.
module drain_prefetch_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push_ok, pop_ok;

    // Next-state for pointers and occupancy
    always_comb begin
        pop_ok   = pop && (count_q != 2'd0);
        push_ok  = push && ((count_q != 2'd2) || pop_ok);
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);

endmodule

// File: rtl/accumulation_drain.sv
// Drains the write-back bank of the accumulation buffer onto an outbound
// valid/ready stream, low chunk of each word first, and pulses done at the end.
module accumulation_drain
    import accumulation_drain_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH       = DEF_OUT_WIDTH,
    parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH,
    parameter int BANK_DEPTH      = DEF_BANK_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [BANK_ADDR_WIDTH:0] num_words,
    output logic                     busy,
    output logic                     done,
    output logic                     ren_wb,
    output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
    input  logic [DATA_WIDTH-1:0]    rdata_wb,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int BEATS = beats_of(DATA_WIDTH, OUT_WIDTH);
    localparam int CNT_W = BANK_ADDR_WIDTH + 1;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BANK_DEPTH);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      words_q, words_d;      // latched drain length
    logic [CNT_W-1:0]      reads_q, reads_d;      // reads issued so far
    logic [CNT_W-1:0]      loaded_q, loaded_d;    // words moved into the serializer
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic                  sval_q, sval_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [1:0]            fifo_count;
    logic                  fifo_empty, fifo_full;
    logic                  pop, ren, handshake, last_beat, last_word_beat, credit;
    logic [2:0]            occupancy;
    logic [CNT_W-1:0]      clamped;

    // The word read last cycle lands in the FIFO; the credit rule keeps it from overflowing
    drain_prefetch_fifo #(.WIDTH(DATA_WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .wdata (rdata_wb),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // FSM, read issue and serializer next-state
    always_comb begin
        handshake      = sval_q && out_ready;
        last_beat      = (idx_q == IDX_W'(BEATS - 1));
        last_word_beat = sval_q && last_beat && (loaded_q == words_q);
        // Reload on the final beat's handshake so consecutive words have no bubble
        pop            = !fifo_empty && (!sval_q || (handshake && last_beat));
        // Words already buffered or on their way, net of the one leaving this cycle
        occupancy      = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        credit         = (occupancy < 3'd2);
        ren            = (state_q == ST_RUN) && (reads_q < words_q) && credit && !fifo_full;
        clamped        = (num_words > DEPTH_C) ? DEPTH_C : num_words;

        state_d    = state_q;
        words_d    = words_q;
        reads_d    = reads_q;
        loaded_d   = loaded_q;
        inflight_d = ren;
        sreg_d     = sreg_q;
        sval_d     = sval_q;
        idx_d      = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    words_d  = clamped;
                    reads_d  = '0;
                    loaded_d = '0;
                    state_d  = (clamped == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (ren) reads_d = reads_q + 1'b1;
                if (handshake && last_word_beat) state_d = ST_FIN;
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            sreg_d   = fifo_rdata;
            sval_d   = 1'b1;
            idx_d    = '0;
            loaded_d = loaded_q + 1'b1;
        end else if (handshake) begin
            sreg_d = sreg_q >> OUT_WIDTH;
            idx_d  = idx_q + 1'b1;
            if (last_beat) sval_d = 1'b0;
        end
    end

    // All state, including the output shift register, clears on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            words_q    <= '0;
            reads_q    <= '0;
            loaded_q   <= '0;
            inflight_q <= 1'b0;
            sreg_q     <= '0;
            sval_q     <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            reads_q    <= reads_d;
            loaded_q   <= loaded_d;
            inflight_q <= inflight_d;
            sreg_q     <= sreg_d;
            sval_q     <= sval_d;
            idx_q      <= idx_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_FIN);
    assign ren_wb    = ren;
    assign radr_wb   = reads_q[BANK_ADDR_WIDTH-1:0];
    assign out_valid = sval_q;
    assign out_data  = sreg_q[OUT_WIDTH-1:0];
    assign out_last  = last_word_beat;

endmodule

// File: tb/tb_accumulation_drain.sv
// Self-checking bench for accumulation_drain: bank model, scoreboard of
// expected beats, and one task per scenario.
module tb_accumulation_drain;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_words;
    logic        busy, done, ren_wb, out_valid, out_ready, out_last;
    logic [6:0]  radr_wb;
    logic [63:0] rdata_wb;
    logic [15:0] out_data;

    logic [63:0] bank [128];
    logic [15:0] exp_data [$];
    logic        exp_last [$];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_addr, reads_cnt, beat_cnt, valid_cnt, done_cnt;
    logic        stall_prev;
    logic [15:0] stall_data;
    logic        stall_last;
    logic [15:0] last_data;

    accumulation_drain u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .ren_wb    (ren_wb),
        .radr_wb   (radr_wb),
        .rdata_wb  (rdata_wb),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: one-cycle read latency
    initial rdata_wb = '0;
    always @(posedge clk) if (ren_wb) rdata_wb <= bank[radr_wb];

    // Scoreboard and stream-protocol monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (ren_wb) begin
                n_cmp++;
                if (radr_wb !== 7'(exp_addr)) begin
                    n_bad++;
                    $display("FAIL read_addr: got %0d want %0d", radr_wb, exp_addr);
                end
                exp_addr++;
                reads_cnt++;
            end
            if (out_valid) valid_cnt++;
            if (done) done_cnt++;
            if (stall_prev) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== stall_data || out_last !== stall_last) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             out_valid, out_data, out_last, stall_data, stall_last);
                end
            end
            if (out_valid && out_ready) begin
                beat_cnt++;
                n_cmp++;
                if (exp_data.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat_unexpected: got d=%h l=%b want no beat", out_data, out_last);
                end else begin
                    logic [15:0] ed;
                    logic        el;
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    if (out_data !== ed || out_last !== el) begin
                        n_bad++;
                        $display("FAIL beat_data: got d=%h l=%b want d=%h l=%b", out_data, out_last, ed, el);
                    end
                end
                last_data = out_data;
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Pulse start for one cycle and queue the beats the drain must produce
    task automatic start_drain(input int n);
        int nw;
        nw = (n > 128) ? 128 : n;
        @(posedge clk); #2;
        exp_addr = 0; reads_cnt = 0; beat_cnt = 0; valid_cnt = 0; done_cnt = 0;
        for (int w = 0; w < nw; w++)
            for (int b = 0; b < 4; b++) begin
                exp_data.push_back(16'(bank[w] >> (16 * b)));
                exp_last.push_back((w == nw - 1) && (b == 3));
            end
        start = 1'b1;
        num_words = 8'(n);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_words = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, ren_wb, out_valid, out_last} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, ren_wb, out_valid, out_last});
        end
        n_cmp++;
        if (radr_wb !== 7'd0 || out_data !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_data: got adr=%0d d=%h want 0 0", radr_wb, out_data);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int first_hs, last_hs, hs, done_cyc, cyc;
        logic busy_at_done;
        first_hs = -1; last_hs = -1; hs = 0; done_cyc = -1; busy_at_done = 1'b1;
        out_ready = 1'b1;
        start_drain(4);
        for (cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                hs++;
            end
            if (done) begin done_cyc = cyc; busy_at_done = busy; end
            @(posedge clk); #2;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (done_cyc < 0) begin n_bad++; $display("FAIL basic_timeout: got no done want done"); end
        n_cmp++;
        if (hs != 16 || last_hs - first_hs != 15) begin
            n_bad++;
            $display("FAIL basic_gapless: got beats=%0d span=%0d want 16 15", hs, last_hs - first_hs);
        end
        n_cmp++;
        if (done_cyc != last_hs + 1 || busy_at_done !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_done: got cyc=%0d busy=%b want cyc=%0d busy=0", done_cyc, busy_at_done, last_hs + 1);
        end
        n_cmp++;
        if (reads_cnt != 4 || done_cnt != 1 || exp_data.size() != 0) begin
            n_bad++;
            $display("FAIL basic_counts: got reads=%0d done=%0d left=%0d want 4 1 0", reads_cnt, done_cnt, exp_data.size());
        end
    endtask

    task automatic test_backpressure();
        int cyc, max_fifo;
        bit seen;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        seen = 0; max_fifo = 0;
        out_ready = 1'b1;
        start_drain(4);
        for (cyc = 0; cyc < 400 && !seen; cyc++) begin
            @(negedge clk);
            if (int'(u_dut.fifo_count) > max_fifo) max_fifo = int'(u_dut.fifo_count);
            if (done) seen = 1;
            @(posedge clk); #2;
            out_ready = pat[(cyc + 1) % 4];
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL bp_timeout: got no done want done"); end
        n_cmp++;
        if (beat_cnt != 16 || reads_cnt != 4 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL bp_counts: got beats=%0d reads=%0d done=%0d want 16 4 1", beat_cnt, reads_cnt, done_cnt);
        end
        n_cmp++;
        if (max_fifo > 2 || exp_data.size() != 0) begin
            n_bad++;
            $display("FAIL bp_fifo: got max=%0d left=%0d want <=2 0", max_fifo, exp_data.size());
        end
    endtask

    task automatic test_zero();
        int done_cyc;
        done_cyc = -1;
        out_ready = 1'b1;
        start_drain(0);
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (done && done_cyc < 0) done_cyc = cyc;
            @(posedge clk); #2;
        end
        @(negedge clk);
        n_cmp++;
        if (done_cnt != 1 || done_cyc < 0 || done_cyc > 1) begin
            n_bad++;
            $display("FAIL zero_done: got pulses=%0d at=%0d want 1 at<=1", done_cnt, done_cyc);
        end
        n_cmp++;
        if (reads_cnt != 0 || valid_cnt != 0) begin
            n_bad++;
            $display("FAIL zero_quiet: got reads=%0d valids=%0d want 0 0", reads_cnt, valid_cnt);
        end
    endtask

    task automatic test_clamp();
        bit seen;
        seen = 0;
        out_ready = 1'b1;
        start_drain(200);
        for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
            @(negedge clk);
            if (done) seen = 1;
            @(posedge clk); #2;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (!seen || reads_cnt != 128 || beat_cnt != 512) begin
            n_bad++;
            $display("FAIL clamp_counts: got done=%0d reads=%0d beats=%0d want 1 128 512", seen, reads_cnt, beat_cnt);
        end
        n_cmp++;
        if (last_data !== 16'h0083 || exp_data.size() != 0) begin
            n_bad++;
            $display("FAIL clamp_last: got %h left=%0d want 0083 0", last_data, exp_data.size());
        end
    endtask

    task automatic test_restart();
        int hs;
        bit seen;
        hs = 0; seen = 0;
        out_ready = 1'b1;
        start_drain(4);
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
            if (done) seen = 1;
            @(posedge clk); #2;
            start = (out_valid && (hs == 3 || hs == 10)) ? 1'b1 : 1'b0;
            num_words = 8'd2;
        end
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (!seen || beat_cnt != 16 || done_cnt != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_ignored: got beats=%0d done=%0d busy=%b want 16 1 0", beat_cnt, done_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        int hs;
        bit seen;
        hs = 0; seen = 0;
        out_ready = 1'b1;
        start_drain(4);
        for (int cyc = 0; cyc < 200 && hs < 7; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
            if (done) seen = 1;
            if (hs < 7) begin @(posedge clk); #2; end
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, ren_wb, out_valid, out_last} !== 5'b0 || radr_wb !== 7'd0 || out_data !== 16'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got ctrl=%b adr=%0d d=%h want 0 0 0",
                     {busy, done, ren_wb, out_valid, out_last}, radr_wb, out_data);
        end
        exp_data.delete();
        exp_last.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        n_cmp++;
        if (seen || done_cnt != 0) begin
            n_bad++;
            $display("FAIL midreset_nodone: got %0d pulses want 0", done_cnt);
        end
        seen = 0;
        start_drain(4);
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            if (done) seen = 1;
            @(posedge clk); #2;
        end
        @(negedge clk);
        n_cmp++;
        if (!seen || beat_cnt != 16 || reads_cnt != 4 || exp_data.size() != 0) begin
            n_bad++;
            $display("FAIL midreset_redrain: got done=%0d beats=%0d reads=%0d want 1 16 4", seen, beat_cnt, reads_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) bank[i] = 64'h0004_0003_0002_0001 + (64'(i) << 48);
        stall_prev = 1'b0;
        last_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_clamp();
        test_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
